// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared settings for the instruction-fetch front end: the default data/address
// width, the depth of the fetch/decode decoupling buffer, the fetch FSM
// encodings and a helper that computes the buffer occupancy after a cycle.
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam int WORD_WIDTH   = 32;
    localparam int BUFFER_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DISCARD  = 2'd2
    } fetch_state_t;

    // Occupancy of the buffer at the end of this cycle. A flush empties it
    // regardless of any push or pop arriving in the same cycle.
    function automatic logic [1:0] next_count(
        input logic [1:0] count,
        input logic       push,
        input logic       pop,
        input logic       flush
    );
        if (flush) begin
            return 2'd0;
        end
        return count + {1'b0, push} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Two-entry synchronous FIFO sitting between fetch and decode.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   push, push_data write an entry (ignored when full unless popping too)
//   pop             drop the head entry (ignored when empty)
//   flush           empty the FIFO; wins over push and pop
//   pop_data        head entry, forced to zero while empty
//   count           number of stored entries (0..2)
//   empty, full     occupancy flags decoded from count
// ---------------------------------------------------------------------------
module fetch_buffer #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [1:0]            count,
    output logic                  empty,
    output logic                  full
);
    import if_fetch_unit_pkg::*;

    logic [DATA_WIDTH-1:0] entries [BUFFER_DEPTH];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    // Occupancy flags and the head word come straight from registers so the
    // consumer never sees a combinational path from the write side.
    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign pop_data = empty ? '0 : entries[rd_ptr];

    // A push into a full buffer is only accepted when the head leaves in the
    // same cycle, which keeps ordering intact and makes overflow impossible.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and storage update. Flush simply rewinds both pointers; stale
    // contents are harmless because pop_data is masked while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            entries[0] <= '0;
            entries[1] <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= next_count(count, do_push, do_pop, 1'b0);
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end. Owns the fetch PC, issues one word read at a
// time over a req/ack handshake and buffers returned words with their PC+4
// for the IF/ID register.
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   freeze                    decode stalled, head entry is held
//   branch_taken              redirect fetch this cycle (highest priority)
//   branch_address            redirect target, word aligned
//   mem_req, mem_addr         registered read request / address
//   mem_rdata, mem_ack        read data and completion strobe
//   pc, instruction, valid    head entry (PC+4, word); zero when empty
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int                    WORD_WIDTH = if_fetch_unit_pkg::WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_address,
    output logic                  mem_req,
    output logic [WORD_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [WORD_WIDTH-1:0] pc,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic                  valid
);
    import if_fetch_unit_pkg::*;

    fetch_state_t                state;
    logic [WORD_WIDTH-1:0]       fetch_pc;
    logic [WORD_WIDTH-1:0]       next_addr;
    logic [2*WORD_WIDTH-1:0]     head;
    logic [1:0]                  count;
    logic [1:0]                  count_next;
    logic                        empty;
    logic                        full;
    logic                        push;
    logic                        pop;

    // A redirect suppresses both the consume and the capture of this cycle;
    // the buffer is flushed instead. Data returned in DISCARD is never pushed.
    assign pop        = !empty && !freeze && !branch_taken;
    assign push       = (state == WAIT_ACK) && mem_ack && !branch_taken;
    assign next_addr  = mem_addr + WORD_WIDTH'(4);
    assign count_next = next_count(count, push, pop, branch_taken);

    fetch_buffer #(
        .DATA_WIDTH(2 * WORD_WIDTH)
    ) u_fetch_buffer (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (branch_taken),
        .push_data({next_addr, mem_rdata}),
        .pop_data (head),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    assign valid       = !empty;
    assign pc          = head[2*WORD_WIDTH-1:WORD_WIDTH];
    assign instruction = head[WORD_WIDTH-1:0];

    // Fetch FSM. At most one request is ever outstanding, and a new one is
    // only launched when the buffer will still have a free slot, so the
    // returning word always has somewhere to go. mem_req/mem_addr stay frozen
    // while a request waits for its ack, including after a redirect (DISCARD),
    // where the stale word is simply dropped when it finally arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_taken) begin
                        fetch_pc <= branch_address;
                    end else if (!full || pop) begin
                        state    <= WAIT_ACK;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                WAIT_ACK: begin
                    if (branch_taken) begin
                        fetch_pc <= branch_address;
                        if (mem_ack) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (mem_ack) begin
                        fetch_pc <= next_addr;
                        if (count_next < 2'd2) begin
                            mem_addr <= next_addr;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (branch_taken) begin
                        fetch_pc <= branch_address;
                    end
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed scoreboard bench for if_fetch_unit. Each scenario pushes the
// (pc, instruction) pairs it expects decode to consume; a monitor pops and
// compares whenever the DUT hands an entry over. Memory returns rdata = addr
// with a configurable number of wait states.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;

    logic [63:0] exp_q [$];
    int          check_count = 0;
    int          pass_count  = 0;
    int          wait_states = 0;
    int          wait_cnt    = 0;
    logic        auto_freeze = 1'b0;

    logic [31:0] t3_addr  [9] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd4, 32'd4, 32'd4, 32'd8};
    logic [31:0] t3_valid [9] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};

    if_fetch_unit #(
        .WORD_WIDTH(32),
        .RESET_PC  (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_address(branch_address),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .pc            (pc),
        .instruction   (instruction),
        .valid         (valid)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point: steps both counters and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus, driven 1 ns after the rising edge. The memory
    // model acks a pending request after wait_states idle cycles and returns
    // the request address as data. With auto_freeze set, decode stalls as
    // soon as the scoreboard has nothing more to expect.
    task automatic applyStimulus(input logic fr, input logic br, input logic [31:0] ba);
        @(posedge clk);
        #1;
        freeze         = auto_freeze ? (exp_q.size() == 0) : fr;
        branch_taken   = br;
        branch_address = ba;
        if (mem_req) begin
            if (wait_cnt == wait_states) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
        mem_rdata = mem_addr;
    endtask

    // Reset for one edge, check the reset values, then release. 'stray'
    // presents an ack on the first post-reset edge, when nothing is pending.
    task automatic doReset(input logic stray);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        freeze       = 1'b1;
        branch_taken = 1'b0;
        mem_ack      = 1'b0;
        auto_freeze  = 1'b0;
        wait_cnt     = 0;
        @(posedge clk);
        #1;
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_pc", pc, 32'd0);
        checkOutput("rst_instr", instruction, 32'd0);
        rst       = 1'b0;
        freeze    = 1'b0;
        mem_ack   = stray;
        mem_rdata = 32'hDEAD_BEEF;
        wait_cnt  = 0;
    endtask

    // Keep running until every expected entry has been consumed, then stall
    // decode so later fetches are not taken. Bounded by 'budget' cycles.
    task automatic drainQueue(input int budget);
        int   n;
        logic done;
        n           = 0;
        done        = 1'b0;
        auto_freeze = 1'b1;
        while (!done && n < budget) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            n++;
            done = freeze;
        end
        auto_freeze = 1'b0;
        checkOutput("drain_done", 32'(done), 32'd1);
        if (!done) begin
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor: an entry is consumed on a cycle where it is valid
    // and neither freeze nor branch_taken holds it. Sampled on the falling
    // edge, well away from the edge that updates the DUT.
    initial begin
        logic [63:0] exp_entry;
        forever begin
            @(negedge clk);
            if (!rst && valid && !freeze && !branch_taken) begin
                if (exp_q.size() == 0) begin
                    check_count++;
                    $display("[TB] FAIL unexpected_output: actual pc=%0h instr=%0h required no output", pc, instruction);
                end else begin
                    exp_entry = exp_q.pop_front();
                    checkOutput("sb_pc", pc, exp_entry[63:32]);
                    checkOutput("sb_instr", instruction, exp_entry[31:0]);
                end
            end
        end
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        // Zero-wait memory: addresses 0,4,8 back to back, one output per cycle.
        $display("[TB] zero-wait streaming");
        doReset(1'b0);
        wait_states = 0;
        exp_q.push_back({32'd4, 32'd0});
        exp_q.push_back({32'd8, 32'd4});
        exp_q.push_back({32'd12, 32'd8});
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t1_req0", 32'(mem_req), 32'd1);
        checkOutput("t1_addr0", mem_addr, 32'd0);
        checkOutput("t1_valid0", 32'(valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t1_addr1", mem_addr, 32'd4);
        checkOutput("t1_valid1", 32'(valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t1_addr2", mem_addr, 32'd8);
        checkOutput("t1_valid2", 32'(valid), 32'd1);
        drainQueue(10);

        // Freeze for 5 cycles: buffer fills, request drops, head is held.
        $display("[TB] freeze fills buffer");
        doReset(1'b0);
        wait_states = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
            if (i >= 1) begin
                checkOutput("t2_pc", pc, 32'd4);
                checkOutput("t2_instr", instruction, 32'd0);
            end
            if (i >= 2) begin
                checkOutput("t2_req", 32'(mem_req), 32'd0);
            end
        end
        exp_q.push_back({32'd4, 32'd0});
        exp_q.push_back({32'd8, 32'd4});
        drainQueue(10);

        // Three wait states: address stable 4 cycles, valid pulses 1 in 4.
        $display("[TB] three wait states");
        doReset(1'b0);
        wait_states = 3;
        exp_q.push_back({32'd4, 32'd0});
        exp_q.push_back({32'd8, 32'd4});
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0, 1'b0, 32'd0);
            checkOutput("t3_addr", mem_addr, t3_addr[k]);
            checkOutput("t3_req", 32'(mem_req), 32'd1);
            checkOutput("t3_valid", 32'(valid), t3_valid[k]);
        end
        drainQueue(10);

        // Branch while waiting; stale ack two cycles later is discarded.
        $display("[TB] branch into discard");
        doReset(1'b0);
        wait_states = 2;
        exp_q.push_back({32'h104, 32'h100});
        applyStimulus(1'b0, 1'b1, 32'h100);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t4_hold_addr", mem_addr, 32'd0);
        checkOutput("t4_hold_req", 32'(mem_req), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t4_idle_req", 32'(mem_req), 32'd0);
        checkOutput("t4_idle_valid", 32'(valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t4_target_addr", mem_addr, 32'h100);
        checkOutput("t4_target_req", 32'(mem_req), 32'd1);
        drainQueue(20);

        // Branch coincident with ack and freeze: acked word and buffer dropped.
        $display("[TB] branch with ack and freeze");
        doReset(1'b0);
        wait_states = 0;
        exp_q.push_back({32'h204, 32'h200});
        applyStimulus(1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h200);
        checkOutput("t5_pre_valid", 32'(valid), 32'd1);
        checkOutput("t5_pre_ack", 32'(mem_ack), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t5_valid", 32'(valid), 32'd0);
        checkOutput("t5_req", 32'(mem_req), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t5_target_addr", mem_addr, 32'h200);
        drainQueue(10);

        // Reset during WAIT_ACK followed by a stray ack in IDLE.
        $display("[TB] reset mid-transaction with stray ack");
        doReset(1'b0);
        wait_states = 3;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
        end
        checkOutput("t6_pre_valid", 32'(valid), 32'd1);
        checkOutput("t6_pre_addr", mem_addr, 32'd4);
        checkOutput("t6_pre_req", 32'(mem_req), 32'd1);
        doReset(1'b1);
        exp_q.push_back({32'd4, 32'd0});
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t6_valid0", 32'(valid), 32'd0);
        checkOutput("t6_addr0", mem_addr, 32'd0);
        checkOutput("t6_req0", 32'(mem_req), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("t6_valid1", 32'(valid), 32'd0);
        drainQueue(20);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
